// File: rtl/mips_lsu_pkg.sv
// Shared types and decode helpers for the MIPS load/store unit.
package mips_lsu_pkg;

    // Operation encoding presented on req_op
    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SB  = 4'd7,
        SH  = 4'd8,
        SW  = 4'd9
    } lsu_op_t;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_RMW_READ  = 3'd2,
        S_RMW_WRITE = 3'd3,
        S_WRITE     = 3'd4,
        S_RESP      = 3'd5
    } lsu_state_t;

    // Encodings above SW are undefined and get faulted.
    function automatic logic is_valid_op(input logic [3:0] op);
        return (op <= 4'(SW));
    endfunction

    // LB..LWR are the loads; they occupy the low end of the encoding.
    function automatic logic is_load(input logic [3:0] op);
        return (op <= 4'(LWR));
    endfunction

    // Halfword accesses need an even address, word accesses a word-aligned one.
    // LWL/LWR and byte accesses are legal at any offset.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (op)
            4'(LH), 4'(LHU), 4'(SH): mis = lo[0];
            4'(LW), 4'(SW):          mis = |lo;
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mips_load_store_unit_align.sv
// Combinational lane logic: big-endian extract/extend/merge for loads and
// byte/halfword insertion for read-modify-write stores.
module lsu_align
    import mips_lsu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] load_word,
    input  logic [31:0] load_rt,
    output logic [31:0] load_result,
    input  logic [31:0] store_word,
    input  logic [15:0] store_data,
    output logic [31:0] store_merged
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [4:0]  shl_amt;
    logic [4:0]  shr_amt;
    logic        is_sb;
    logic        is_sh;

    // Offset 0 is the most significant byte, so a right shift of 8*(3-k)
    // brings lane k down to bits [7:0]; 3-k on two bits is just ~k.
    assign shl_amt  = {byte_off, 3'b000};
    assign shr_amt  = {~byte_off, 3'b000};
    assign byte_val = 8'(load_word >> shr_amt);
    assign half_val = byte_off[1] ? load_word[15:0] : load_word[31:16];

    // Load result selection, including the unaligned LWL/LWR merges with rt
    always_comb begin
        load_result = '0;
        case (op)
            4'(LB):  load_result = {{24{byte_val[7]}}, byte_val};
            4'(LBU): load_result = {24'h0, byte_val};
            4'(LH):  load_result = {{16{half_val[15]}}, half_val};
            4'(LHU): load_result = {16'h0, half_val};
            4'(LW):  load_result = load_word;
            4'(LWL): load_result = (load_word << shl_amt)
                                 | (load_rt & ((32'h1 << shl_amt) - 32'h1));
            4'(LWR): load_result = (load_word >> shr_amt)
                                 | (load_rt & ~(32'hFFFF_FFFF >> shr_amt));
            default: load_result = '0;
        endcase
    end

    assign is_sb = (op == 4'(SB));
    assign is_sh = (op == 4'(SH));

    // Per-lane store merge: lane gi occupies bits [31-8*gi -: 8]
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic [7:0] sh_byte;
            // Even lane of a halfword takes the upper data byte
            assign sh_byte = LANE[0] ? store_data[7:0] : store_data[15:8];
            assign store_merged[31-8*gi -: 8] =
                (is_sb && (byte_off == LANE))       ? store_data[7:0] :
                (is_sh && (byte_off[1] == LANE[1])) ? sh_byte :
                                                      store_word[31-8*gi -: 8];
        end
    endgenerate

endmodule

// File: rtl/mips_load_store_unit.sv
// Load/store sequencer in front of a word-addressed memory without byte
// enables. One request at a time; sub-word stores are read-modify-write.
module mips_load_store_unit
    import mips_lsu_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    lsu_state_t  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rt_q, rt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] result_q, result_d;
    logic        fault_q, fault_d;

    logic [31:0] load_result;
    logic [31:0] store_merged;

    // Loads merge straight from the memory bus at the end of the LOAD cycle;
    // stores merge from the word captured during RMW_READ.
    lsu_align u_align (
        .op           (op_q),
        .byte_off     (addr_q[1:0]),
        .load_word    (data_readdata),
        .load_rt      (rt_q),
        .load_result  (load_result),
        .store_word   (word_q),
        .store_data   (wdata_q[15:0]),
        .store_merged (store_merged)
    );

    // State and transaction registers; reset abandons any request in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rt_q     <= '0;
            word_q   <= '0;
            result_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rt_q     <= rt_d;
            word_q   <= word_d;
            result_q <= result_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state and capture logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rt_d     = rt_q;
        word_d   = word_q;
        result_d = result_q;
        fault_d  = fault_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d     = req_op;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rt_d     = req_rt;
                    result_d = '0;
                    fault_d  = 1'b0;
                    if (!is_valid_op(req_op) ||
                        (CHECK_ALIGN && is_misaligned(req_op, req_addr[1:0]))) begin
                        fault_d = 1'b1;
                        state_d = S_RESP;
                    end else if (is_load(req_op)) begin
                        state_d = S_LOAD;
                    end else if (req_op == 4'(SW)) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RMW_READ;
                    end
                end
            end
            S_LOAD: begin
                result_d = load_result;
                state_d  = S_RESP;
            end
            S_RMW_READ: begin
                word_d  = data_readdata;
                state_d = S_RMW_WRITE;
            end
            S_RMW_WRITE: state_d = S_RESP;
            S_WRITE:     state_d = S_RESP;
            S_RESP:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs decode only from registered state so reset drops strobes at once
    always_comb begin
        req_ready      = (state_q == S_IDLE);
        resp_valid     = (state_q == S_RESP);
        resp_rdata     = (state_q == S_RESP) ? result_q : 32'h0;
        resp_fault     = (state_q == S_RESP) && fault_q;
        data_address   = {addr_q[31:2], 2'b00};
        data_read      = (state_q == S_LOAD) || (state_q == S_RMW_READ);
        data_write     = (state_q == S_RMW_WRITE) || (state_q == S_WRITE);
        data_writedata = 32'h0;
        if (state_q == S_WRITE) begin
            data_writedata = wdata_q;
        end else if (state_q == S_RMW_WRITE) begin
            data_writedata = store_merged;
        end
    end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed-vector bench for mips_load_store_unit with a word memory model.
module tb_mips_load_store_unit;
    import mips_lsu_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rt;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    logic [31:0] mem [0:1023];

    int vectors     = 0;
    int miscompares = 0;
    int wr_cycles   = 0;
    int resp_cycles = 0;
    int both_cycles = 0;

    // results of the most recent transaction
    logic [31:0] r_rdata;
    logic        r_fault;
    int          r_lat;
    int          r_nrd;
    int          r_nwr;
    logic        r_got;

    mips_load_store_unit #(.CHECK_ALIGN(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rt         (req_rt),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: combinational read, write on the rising edge
    assign data_readdata = mem[data_address[11:2]];
    always @(posedge clk) begin
        if (data_write) mem[data_address[11:2]] <= data_writedata;
    end

    // strobe/response monitors sampled mid-cycle
    always @(negedge clk) begin
        if (data_write) wr_cycles++;
        if (resp_valid) resp_cycles++;
        if (data_read && data_write) both_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request starting at a negedge; returns at the negedge of the
    // response cycle (or after a bounded wait).
    task automatic run_req(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rt);
        int guard;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rt = rt;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        r_lat = 0; r_nrd = 0; r_nwr = 0; r_got = 1'b0; r_rdata = 'x; r_fault = 1'bx;
        while (!r_got && r_lat < 10) begin
            r_lat++;
            if (data_read)  r_nrd++;
            if (data_write) r_nwr++;
            if (resp_valid) begin
                r_got   = 1'b1;
                r_rdata = resp_rdata;
                r_fault = resp_fault;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rt,
                             input logic [31:0] exp_rdata, input logic exp_fault,
                             input int exp_lat, input int exp_rd, input int exp_wr);
        run_req(op, addr, wd, rt);
        $display("txn %s op=%0d addr=0x%08h rdata=0x%08h fault=%0b lat=%0d rd=%0d wr=%0d",
                 tag, op, addr, r_rdata, r_fault, r_lat, r_nrd, r_nwr);
        check({tag, "_resp"},  32'(r_got), 32'd1);
        check({tag, "_rdata"}, r_rdata, exp_rdata);
        check({tag, "_fault"}, 32'(r_fault), 32'(exp_fault));
        check({tag, "_lat"},   32'(r_lat), 32'(exp_lat));
        check({tag, "_nrd"},   32'(r_nrd), 32'(exp_rd));
        check({tag, "_nwr"},   32'(r_nwr), 32'(exp_wr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;
        int resp_before;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_rt = '0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ready",     32'(req_ready),  32'd1);
        check("rst_resp",      32'(resp_valid), 32'd0);
        check("rst_fault",     32'(resp_fault), 32'd0);
        check("rst_rdata",     resp_rdata,      32'h0);
        check("rst_read",      32'(data_read),  32'd0);
        check("rst_write",     32'(data_write), 32'd0);
        check("rst_addr",      data_address,    32'h0);
        check("rst_wdata",     data_writedata,  32'h0);
        reset = 1'b0;
        @(negedge clk);

        // byte loads
        mem[32'h100 >> 2] = 32'h8899AABB;
        run_check("lb_102",  LB,  32'h102, 32'h0, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1, 0);
        run_check("lbu_102", LBU, 32'h102, 32'h0, 32'h0, 32'h000000AA, 1'b0, 2, 1, 0);

        // read-modify-write stores
        mem[32'h100 >> 2] = 32'h11223344;
        run_check("sb_103", SB, 32'h103, 32'h000000CC, 32'h0, 32'h0, 1'b0, 3, 1, 1);
        @(negedge clk);
        check("sb_103_mem", mem[32'h100 >> 2], 32'h112233CC);
        run_check("sh_100", SH, 32'h100, 32'h0000BEEF, 32'h0, 32'h0, 1'b0, 3, 1, 1);
        @(negedge clk);
        check("sh_100_mem", mem[32'h100 >> 2], 32'hBEEF33CC);

        // word, halfword and LWL/LWR merges
        mem[32'h100 >> 2] = 32'h11223344;
        run_check("lwl_101", LWL, 32'h101, 32'h0, 32'hAABBCCDD, 32'h223344DD, 1'b0, 2, 1, 0);
        run_check("lwr_101", LWR, 32'h101, 32'h0, 32'hAABBCCDD, 32'hAABB1122, 1'b0, 2, 1, 0);
        run_check("lwl_103", LWL, 32'h103, 32'h0, 32'hAABBCCDD, 32'h44BBCCDD, 1'b0, 2, 1, 0);
        run_check("lwr_100", LWR, 32'h100, 32'h0, 32'hAABBCCDD, 32'hAABBCC11, 1'b0, 2, 1, 0);
        run_check("lwl_100", LWL, 32'h100, 32'h0, 32'hAABBCCDD, 32'h11223344, 1'b0, 2, 1, 0);
        run_check("lw_100",  LW,  32'h100, 32'h0, 32'hAABBCCDD, 32'h11223344, 1'b0, 2, 1, 0);
        run_check("lh_102",  LH,  32'h102, 32'h0, 32'h0, 32'h00003344, 1'b0, 2, 1, 0);
        run_check("lhu_100", LHU, 32'h100, 32'h0, 32'h0, 32'h00001122, 1'b0, 2, 1, 0);
        run_check("lb_100",  LB,  32'h100, 32'h0, 32'h0, 32'h00000011, 1'b0, 2, 1, 0);

        // faults: misaligned and undefined opcodes never touch memory
        run_check("lh_101", LH,    32'h101, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        run_check("sw_102", SW,    32'h102, 32'h5A5A5A5A, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        run_check("lw_101", LW,    32'h101, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        run_check("op_f",   4'hF,  32'h100, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        check("sw_102_mem", mem[32'h100 >> 2], 32'h11223344);

        // asynchronous reset during the RMW read of SB 0x104
        mem[32'h104 >> 2] = 32'hCAFEF00D;
        req_valid = 1'b1; req_op = SB; req_addr = 32'h104; req_wdata = 32'h55; req_rt = '0;
        for (int g = 0; g < 20 && !req_ready; g++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_rd_before", 32'(data_read), 32'd1);
        wr_before = wr_cycles;
        resp_before = resp_cycles;
        #1 reset = 1'b1;
        #1;
        check("rst_mid_rd_drop", 32'(data_read), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        $display("txn rst_mid op=%0d addr=0x%08h writes=%0d resps=%0d",
                 SB, 32'h104, wr_cycles - wr_before, resp_cycles - resp_before);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        check("rst_mid_nwr",   32'(wr_cycles - wr_before), 32'd0);
        check("rst_mid_nresp", 32'(resp_cycles - resp_before), 32'd0);
        check("rst_mid_mem",   mem[32'h104 >> 2], 32'hCAFEF00D);

        // back-to-back SW then LW with req_valid held throughout
        req_valid = 1'b1; req_op = SW; req_addr = 32'h200; req_wdata = 32'h12345678; req_rt = '0;
        for (int g = 0; g < 20 && !req_ready; g++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        req_op = LW; req_wdata = 32'h0;
        check("b2b_c1_ready", 32'(req_ready),  32'd0);
        check("b2b_c1_write", 32'(data_write), 32'd1);
        check("b2b_c1_wdata", data_writedata,  32'h12345678);
        @(negedge clk);
        check("b2b_c2_ready", 32'(req_ready),  32'd0);
        check("b2b_c2_resp",  32'(resp_valid), 32'd1);
        @(negedge clk);
        check("b2b_c3_ready", 32'(req_ready),  32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_c4_read",  32'(data_read),  32'd1);
        check("b2b_c4_ready", 32'(req_ready),  32'd0);
        @(negedge clk);
        $display("txn b2b_lw op=%0d addr=0x%08h rdata=0x%08h resp=%0b",
                 LW, 32'h200, resp_rdata, resp_valid);
        check("b2b_c5_resp",  32'(resp_valid), 32'd1);
        check("b2b_c5_rdata", resp_rdata,      32'h12345678);
        check("b2b_mem",      mem[32'h200 >> 2], 32'h12345678);

        check("strobes_exclusive", 32'(both_cycles), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
